// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared definitions for the trap controller: FSM state
//                encoding, machine interrupt codes and bit positions,
//                synchronous exception codes, and the mcause builder for
//                interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // Machine interrupt cause codes
    localparam logic [3:0] c_irq_code_mei = 4'd11;
    localparam logic [3:0] c_irq_code_msi = 4'd3;
    localparam logic [3:0] c_irq_code_mti = 4'd7;

    // Bit positions of the pending/enable vectors, ordered {MEI, MTI, MSI}
    localparam int c_irq_bit_mei = 2;
    localparam int c_irq_bit_mti = 1;
    localparam int c_irq_bit_msi = 0;

    // Synchronous exception cause codes reported by write-back
    localparam logic [3:0] c_exc_instr_misaligned = 4'd0;
    localparam logic [3:0] c_exc_illegal_instr    = 4'd2;
    localparam logic [3:0] c_exc_load_misaligned  = 4'd4;
    localparam logic [3:0] c_exc_store_misaligned = 4'd6;

    // mcause bit that distinguishes interrupts from exceptions
    localparam int c_mcause_irq_bit = 31;

    function automatic logic [31:0] irq_mcause(input logic [3:0] code);
        logic [31:0] v;
        v                   = {28'd0, code};
        v[c_mcause_irq_bit] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_irq_prio.sv
`default_nettype none
// ============================================================================
//  Module      : trap_irq_prio
//  Description : Fixed-priority selector for the machine interrupts that are
//                both pending and enabled. Priority MEI > MSI > MTI.
//  Ports       : i_pend_en - pending & enable, ordered {MEI, MTI, MSI}
//                o_valid   - at least one interrupt is selectable
//                o_code    - cause code of the winning interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_irq_prio
    import trap_pkg::*;
(
    input  logic [2:0] i_pend_en,
    output logic       o_valid,
    output logic [3:0] o_code
);

    always_comb begin
        o_valid = |i_pend_en;
        o_code  = c_irq_code_mei;
        if (i_pend_en[c_irq_bit_mei]) begin
            o_code = c_irq_code_mei;
        end else if (i_pend_en[c_irq_bit_msi]) begin
            o_code = c_irq_code_msi;
        end else if (i_pend_en[c_irq_bit_mti]) begin
            o_code = c_irq_code_mti;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap / MRET sequencer. Accepts one event per
//                cycle in IDLE (exception > interrupt > MRET), strobes the
//                CSR trap write, redirects fetch, then holds the pipeline
//                flushed for FLUSH_CYCLES extra cycles. All outputs are
//                registered.
//  Parameter   : FLUSH_CYCLES (0..15) - drain cycles after the redirect
//  Macro       : TRAP_CTRL_VECTORED_EN - vectored interrupt targets when
//                mtvec_i[1:0] == 2'b01
//  Ports       : clk_i, rst_i (sync, active-high)
//                exc_*_i          - write-back exception and its details
//                wb_valid_i/wb_next_pc_i - retiring instruction, successor PC
//                mret_i           - MRET in write-back
//                xint_m*ip_i      - level interrupt lines
//                mstatus_mie_i, mie_i, mtvec_i, mepc_i - CSR state
//                trap_*_o         - CSR trap-write strobe and payload
//                mret_we_o        - mstatus restore strobe
//                redirect_*_o     - fetch redirect
//                flush_o, busy_o  - pipeline flush, sequencer busy
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_tval_i,
    input  logic [31:0] exc_pc_i,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_next_pc_i,
    input  logic        mret_i,
    input  logic        xint_meip_i,
    input  logic        xint_mtip_i,
    input  logic        xint_msip_i,
    input  logic        mstatus_mie_i,
    input  logic [2:0]  mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        trap_we_o,
    output logic [31:0] trap_mcause_o,
    output logic [31:0] trap_mepc_o,
    output logic [31:0] trap_mtval_o,
    output logic        mret_we_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        busy_o
);

    // Counter value loaded on entry to DRAIN; DRAIN exits when it reaches 0
    localparam logic [3:0] c_drain_last = 4'(FLUSH_CYCLES) - 4'd1;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_target, w_target_nxt;

    logic        w_trap_we_nxt, w_mret_we_nxt, w_redirect_valid_nxt;
    logic [31:0] w_mcause_nxt, w_mepc_nxt, w_mtval_nxt, w_redirect_pc_nxt;
    logic        w_busy_nxt;

    logic [2:0]  w_pend_en;
    logic        w_irq_valid;
    logic [3:0]  w_irq_code;
    logic        w_irq_take;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_irq_target;

    assign w_pend_en    = {xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i;
    assign w_irq_take   = wb_valid_i & mstatus_mie_i & w_irq_valid;
    assign w_mtvec_base = {mtvec_i[31:2], 2'b00};

    trap_irq_prio u_irq_prio (
        .i_pend_en (w_pend_en),
        .o_valid   (w_irq_valid),
        .o_code    (w_irq_code)
    );

`ifdef TRAP_CTRL_VECTORED_EN
    assign w_irq_target = (mtvec_i[1:0] == 2'b01)
                        ? w_mtvec_base + {26'd0, w_irq_code, 2'b00}
                        : w_mtvec_base;
`else
    // Mode bits have no effect in this build
    logic w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = ^mtvec_i[1:0];
    assign w_irq_target        = w_mtvec_base;
`endif

    // State and sequencing registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_target <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_target_nxt         = r_target;
        w_trap_we_nxt        = 1'b0;
        w_mret_we_nxt        = 1'b0;
        w_redirect_valid_nxt = 1'b0;
        w_mcause_nxt         = trap_mcause_o;
        w_mepc_nxt           = trap_mepc_o;
        w_mtval_nxt          = trap_mtval_o;
        w_redirect_pc_nxt    = redirect_pc_o;

        case (r_state)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    w_mcause_nxt  = {28'd0, exc_cause_i};
                    w_mepc_nxt    = exc_pc_i;
                    w_mtval_nxt   = exc_tval_i;
                    w_target_nxt  = w_mtvec_base;
                    w_trap_we_nxt = 1'b1;
                    w_state_nxt   = ST_SAVE;
                end else if (w_irq_take) begin
                    w_mcause_nxt  = irq_mcause(w_irq_code);
                    w_mepc_nxt    = wb_next_pc_i;
                    w_mtval_nxt   = 32'd0;
                    w_target_nxt  = w_irq_target;
                    w_trap_we_nxt = 1'b1;
                    w_state_nxt   = ST_SAVE;
                end else if (mret_i) begin
                    // MRET skips SAVE; its target is mepc as seen now
                    w_mret_we_nxt        = 1'b1;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = mepc_i;
                    w_state_nxt          = ST_REDIRECT;
                end
            end
            ST_SAVE: begin
                w_redirect_valid_nxt = 1'b1;
                w_redirect_pc_nxt    = r_target;
                w_state_nxt          = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (FLUSH_CYCLES == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = c_drain_last;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every non-IDLE state flushes, so flush and busy share one term
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trap_we_o        <= 1'b0;
            trap_mcause_o    <= 32'd0;
            trap_mepc_o      <= 32'd0;
            trap_mtval_o     <= 32'd0;
            mret_we_o        <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'd0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            trap_we_o        <= w_trap_we_nxt;
            trap_mcause_o    <= w_mcause_nxt;
            trap_mepc_o      <= w_mepc_nxt;
            trap_mtval_o     <= w_mtval_nxt;
            mret_we_o        <= w_mret_we_nxt;
            redirect_valid_o <= w_redirect_valid_nxt;
            redirect_pc_o    <= w_redirect_pc_nxt;
            flush_o          <= w_busy_nxt;
            busy_o           <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning extra flush cycles held after redirect (range 0..15).
REQ-002 SHALL have ports clk_i (input, 1, the one clock) and rst_i (input, 1, synchronous active-high reset).
REQ-003 SHALL have exc_valid_i (input, 1), the synchronous exception from write-back.
REQ-004 SHALL have exc_cause_i (input, 4), the exception code.
REQ-005 SHALL have exc_tval_i (input, 32), the faulting value.
REQ-006 SHALL have exc_pc_i (input, 32), the PC of the write-back instruction.
REQ-007 SHALL have wb_valid_i (input, 1), which marks an instruction retiring this cycle, and wb_next_pc_i (input, 32), that instruction's successor PC.
REQ-008 SHALL have mret_i (input, 1), which marks an MRET in write-back.
REQ-009 SHALL have xint_meip_i, xint_mtip_i and xint_msip_i (input, 1 each), the level interrupt lines.
REQ-010 SHALL have mstatus_mie_i (input, 1), mie_i (input, 3, ordered {MEIE,MTIE,MSIE}), mtvec_i (input, 32) and mepc_i (input, 32).
REQ-011 SHALL have trap_we_o (output, 1), a one-cycle CSR trap-write strobe, plus trap_mcause_o, trap_mepc_o and trap_mtval_o (output, 32 each).
REQ-012 SHALL have mret_we_o (output, 1), a one-cycle mstatus-restore strobe.
REQ-013 SHALL have redirect_valid_o (output, 1) and redirect_pc_o (output, 32).
REQ-014 SHALL have flush_o (output, 1), the pipeline flush, and busy_o (output, 1), high when state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SAVE, REDIRECT and DRAIN; all outputs SHALL be registered.
REQ-016 In IDLE, event priority SHALL be: exc_valid_i, then enabled interrupt, then mret_i; at most one event SHALL be accepted per cycle.
REQ-017 Exception accepted at cycle N: the block SHALL latch mcause={28'b0,exc_cause_i}, mepc=exc_pc_i and mtval=exc_tval_i, and go to SAVE at N+1.
REQ-018 An interrupt SHALL be taken only when wb_valid_i && mstatus_mie_i && |(pending & mie_i).
REQ-019 Interrupt priority SHALL be MEI (11) > MSI (3) > MTI (7); the block SHALL latch mcause={1'b1,27'b0,code}, mepc=wb_next_pc_i and mtval=0.
REQ-020 SAVE SHALL last 1 cycle with trap_we_o=1 and flush_o=1, then go to REDIRECT.
REQ-021 For a trap, REDIRECT SHALL last 1 cycle with redirect_valid_o=1 and redirect_pc_o={mtvec_i[31:2],2'b00}.
REQ-022 MRET accepted at N SHALL enter REDIRECT at N+1 (SAVE skipped) with mret_we_o=1 and redirect_pc_o equal to mepc_i sampled at N.
REQ-023 After REDIRECT, the block SHALL enter DRAIN for FLUSH_CYCLES cycles using a 4-bit down-counter, then return to IDLE; when FLUSH_CYCLES=0, REDIRECT SHALL go directly to IDLE.
REQ-024 flush_o SHALL be high in SAVE, REDIRECT and DRAIN.
REQ-025 All inputs SHALL be ignored while busy_o=1; interrupt lines are level-sensitive and SHALL be re-evaluated in IDLE.
REQ-026 exc_valid_i and mret_i asserted together SHALL be handled as the exception only.

Reset
REQ-027 When rst_i=1 at a clock edge, state SHALL be IDLE, the counter 0, and every output 0, including redirect_pc_o and the trap_* buses.
REQ-028 Reset mid-sequence SHALL abort it; no trap_we_o, mret_we_o or redirect_valid_o SHALL be emitted after rst_i is sampled high.

Configuration
REQ-029 With TRAP_CTRL_VECTORED_EN defined, an interrupt trap with mtvec_i[1:0]==2'b01 SHALL redirect to {mtvec_i[31:2],2'b00}+4*code; exceptions SHALL always use the base address.
REQ-030 Without TRAP_CTRL_VECTORED_EN, all traps SHALL use the base address and mtvec_i[1:0] SHALL be ignored.

Structure
REQ-031 The package trap_pkg SHALL hold the state encoding, interrupt codes (11/3/7), the exception codes (0,2,4,6) and the interrupt-bit position.
REQ-032 Interrupt selection SHALL be a combinational sub-module trap_irq_prio (pending & enable -> valid, code).

Verification
REQ-033 exc_valid_i=1, cause=2, pc=0x100, tval=0x00000013 at N -> trap_we_o at N+1 with mcause=2, mepc=0x100, mtval=0x13; redirect at N+2 to 0x80 when mtvec_i=0x80; busy_o low at N+5 with FLUSH_CYCLES=2.
REQ-034 MIE=1, mie_i=3'b111, meip and mtip high, wb_valid_i=1, wb_next_pc_i=0x204 -> mcause=0x8000000B, mepc=0x204.
REQ-035 MIE=0 with meip high for 10 cycles -> no trap_we_o; set MIE=1 with wb_valid_i=1 -> trap taken next cycle.
REQ-036 mret_i=1 with mepc_i=0x300 at N -> mret_we_o and redirect to 0x300 at N+1; no trap_we_o.
REQ-037 Exception while busy_o=1 -> ignored; rst_i=1 during SAVE -> all outputs 0 next cycle, no redirect.
REQ-038 With TRAP_CTRL_VECTORED_EN defined, mtvec_i=0x1001 and MTI -> redirect_pc_o=0x101C.
